// File: rtl/uart_cmd_defs_pkg.sv
// Shared command/reply codes and FSM encodings for the UART command engine.
package uart_cmd_defs;

    localparam logic [7:0] CMD_TEST    = 8'h74;
    localparam logic [7:0] CMD_WRITE   = 8'h77;
    localparam logic [7:0] CMD_READ    = 8'h72;
    localparam logic [7:0] CMD_ECHO    = 8'h65;

    localparam logic [7:0] RSP_OK      = 8'h4B;
    localparam logic [7:0] RSP_ERR     = 8'h3F;
    localparam logic [7:0] RSP_TIMEOUT = 8'h21;

    typedef enum logic [2:0] {
        P_IDLE,
        P_T_ARG,
        P_W_ADDR,
        P_W_DATA,
        P_R_ADDR,
        P_E_CNT,
        P_E_DATA
    } parse_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_PULSE,
        TX_GUARD,
        TX_WAIT
    } tx_state_t;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmd_tx_fifo.sv
// Reply byte FIFO; head word is visible on pop_data without a read cycle.
module cmd_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk100mhz,
    input  logic       cpu_reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // The extra pointer bit separates a full ring from an empty one.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk100mhz) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (cpu_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_engine.sv
// Byte-protocol command parser with register file and a drained reply FIFO.
//
// parser state | meaning
// P_IDLE       | waiting for a command byte
// P_T_ARG      | 't' seen, next byte is returned plus INCR
// P_W_ADDR     | 'w' seen, next byte is the register address
// P_W_DATA     | next byte is written to the latched address
// P_R_ADDR     | 'r' seen, next byte selects the register to return
// P_E_CNT      | 'e' seen, next byte is the echo length
// P_E_DATA     | echoing bytes until the length counter runs out
//
// tx state     | meaning
// TX_IDLE      | waiting for a queued byte and an idle transmitter
// TX_PULSE     | tx_send asserted for this single cycle
// TX_GUARD     | tx_busy ignored while the transmitter picks up the byte
// TX_WAIT      | waiting for tx_busy to fall
module uart_cmd_engine #(
    parameter int NUM_REGS       = 4,
    parameter int TX_DEPTH       = 16,
    parameter int TIMEOUT_CYCLES = 10000000,
    parameter int INCR           = 1
) (
    input  logic                  clk100mhz,
    input  logic                  cpu_reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  tx_busy,
    output logic                  tx_send,
    output logic [7:0]            tx_data,
    output logic [8*NUM_REGS-1:0] regs_out,
    output logic                  cmd_error,
    output logic                  tx_overflow
);

    import uart_cmd_defs::*;

    localparam int ADDR_W = addr_width(NUM_REGS);
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_ONE  = 1;
    localparam logic [7:0] INCR_B = 8'(INCR);
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

    parse_state_t p_state, p_next;
    tx_state_t    tx_state, tx_next;

    logic [7:0]       addr_q, addr_next;
    logic [7:0]       ecnt_q, ecnt_next;
    logic [TMO_W-1:0] tmo_q, tmo_next;
    logic             push_q, push_next;
    logic [7:0]       push_byte_q, push_byte_next;
    logic             err_next;
    logic             wr_en;
    logic [7:0]       rd_byte;
    logic             rx_addr_ok, lat_addr_ok, tmo_expire;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       tx_data_q;
    logic             fifo_pop, fifo_empty, fifo_full;
    logic [7:0]       fifo_rdata;

    assign rx_addr_ok  = ({1'b0, rx_data} < 9'(NUM_REGS));
    assign lat_addr_ok = ({1'b0, addr_q} < 9'(NUM_REGS));
    assign rd_byte     = regs_q[rx_data[ADDR_W-1:0]];
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign tmo_expire  = TMO_EN && (p_state != P_IDLE) && !rx_valid && (tmo_q == '0);

    always_comb begin
        p_next         = p_state;
        addr_next      = addr_q;
        ecnt_next      = ecnt_q;
        tmo_next       = tmo_q;
        push_next      = 1'b0;
        push_byte_next = RSP_ERR;
        err_next       = 1'b0;
        wr_en          = 1'b0;
        if (rx_valid) begin
            tmo_next = TMO_LOAD;
            case (p_state)
                P_IDLE: begin
                    case (rx_data)
                        CMD_TEST:  p_next = P_T_ARG;
                        CMD_WRITE: p_next = P_W_ADDR;
                        CMD_READ:  p_next = P_R_ADDR;
                        CMD_ECHO:  p_next = P_E_CNT;
                        default: begin
                            push_next = 1'b1;
                            err_next  = 1'b1;
                        end
                    endcase
                end
                P_T_ARG: begin
                    push_next      = 1'b1;
                    push_byte_next = rx_data + INCR_B;
                    p_next         = P_IDLE;
                end
                P_W_ADDR: begin
                    addr_next = rx_data;
                    p_next    = P_W_DATA;
                end
                P_W_DATA: begin
                    push_next = 1'b1;
                    p_next    = P_IDLE;
                    if (lat_addr_ok) begin
                        wr_en          = 1'b1;
                        push_byte_next = RSP_OK;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                P_R_ADDR: begin
                    push_next = 1'b1;
                    p_next    = P_IDLE;
                    if (rx_addr_ok) begin
                        push_byte_next = rd_byte;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                P_E_CNT: begin
                    if (rx_data == 8'd0) begin
                        push_next      = 1'b1;
                        push_byte_next = RSP_OK;
                        p_next         = P_IDLE;
                    end else begin
                        ecnt_next = rx_data;
                        p_next    = P_E_DATA;
                    end
                end
                P_E_DATA: begin
                    push_next      = 1'b1;
                    push_byte_next = rx_data;
                    ecnt_next      = ecnt_q - 8'd1;
                    if (ecnt_q == 8'd1) begin
                        p_next = P_IDLE;
                    end
                end
                default: p_next = P_IDLE;
            endcase
        end else if (tmo_expire) begin
            push_next      = 1'b1;
            push_byte_next = RSP_TIMEOUT;
            err_next       = 1'b1;
            p_next         = P_IDLE;
        end else if ((p_state != P_IDLE) && (tmo_q != '0)) begin
            tmo_next = tmo_q - TMO_ONE;
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (cpu_reset) begin
            p_state     <= P_IDLE;
            addr_q      <= '0;
            ecnt_q      <= '0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
            cmd_error   <= 1'b0;
        end else begin
            p_state     <= p_next;
            addr_q      <= addr_next;
            ecnt_q      <= ecnt_next;
            tmo_q       <= tmo_next;
            push_q      <= push_next;
            push_byte_q <= push_byte_next;
            cmd_error   <= err_next;
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (cpu_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[addr_q[ADDR_W-1:0]] <= rx_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[8*g +: 8] = regs_q[g];
    end

    always_ff @(posedge clk100mhz) begin
        if (cpu_reset) begin
            tx_overflow <= 1'b0;
        end else if (push_q && fifo_full) begin
            tx_overflow <= 1'b1;
        end
    end

    cmd_tx_fifo #(
        .DEPTH(TX_DEPTH)
    ) u_fifo (
        .clk100mhz(clk100mhz),
        .cpu_reset(cpu_reset),
        .push     (push_q),
        .push_data(push_byte_q),
        .pop      (fifo_pop),
        .pop_data (fifo_rdata),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_comb begin
        tx_next  = tx_state;
        fifo_pop = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    fifo_pop = 1'b1;
                    tx_next  = TX_PULSE;
                end
            end
            TX_PULSE: tx_next = TX_GUARD;
            TX_GUARD: tx_next = TX_WAIT;
            TX_WAIT: begin
                if (!tx_busy) begin
                    tx_next = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk100mhz) begin
        if (cpu_reset) begin
            tx_state  <= TX_IDLE;
            tx_data_q <= '0;
        end else begin
            tx_state <= tx_next;
            if (fifo_pop) begin
                tx_data_q <= fifo_rdata;
            end
        end
    end

    assign tx_send = (tx_state == TX_PULSE);
    assign tx_data = tx_data_q;

endmodule
